// File: rtl/bus_sequencer_pkg.sv
// Shared types for the bus sequencer and the control decoder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bus_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEM_DATA  = 3'd1,
    MEM_FETCH = 3'd2,
    IO_ACC    = 3'd3,
    HALTED    = 3'd4
  } seqState_t;

  // Control-word bit positions shared with the instruction decoder.
  localparam int CW_RAM_LD = 18;
  localparam int CW_RAM_ST = 19;
  localparam int CW_IO_W   = 21;
  localparam int CW_IO_R   = 22;
  localparam int CW_HALT   = 24;

  // Extract {halt, ioR, ioW, ramSt, ramLd} from a full control word.
  function automatic logic [4:0] ctrlAccBits(input logic [31:0] cw);
    return {cw[CW_HALT], cw[CW_IO_R], cw[CW_IO_W], cw[CW_RAM_ST], cw[CW_RAM_LD]};
  endfunction

  // True when more than one access-type bit is set.
  function automatic logic multiBit(input logic a, input logic b, input logic c, input logic d);
    return (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// RAM + IO bus between the sequencer (master) and the memory/IO system (slave).
// Latency: n/a (wiring only).
// Backpressure: RAM has fixed wait states; IO stalls on io_ack.
interface bus_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_rd;
  logic              io_wr;
  logic              io_ack;
  logic [DATA_W-1:0] io_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_re, mem_we, io_addr, io_wdata, io_rd, io_wr,
    input  mem_rdata, io_ack, io_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_re, mem_we, io_addr, io_wdata, io_rd, io_wr,
    output mem_rdata, io_ack, io_rdata
  );
endinterface

// File: rtl/bus_sequencer_io_handshake.sv
// IO req/ack handshake: holds io_rd/io_wr until io_ack or the timeout expires.
// Latency: strobe rises the cycle after start; done flags the ack/timeout cycle.
// Backpressure: waits on io_ack for at most IO_TIMEOUT strobe cycles.
module io_handshake #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              isRead,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ioAck,
  output logic              ioRd,
  output logic              ioWr,
  output logic [ADDR_W-1:0] ioAddr,
  output logic [DATA_W-1:0] ioWdata,
  output logic              done,
  output logic              timedOut,
  output logic              readAcc
);
  // Counter value in the last strobe cycle before giving up.
  localparam logic [7:0] LAST = 8'(IO_TIMEOUT - 1);

  logic [7:0] toCnt;
  logic       busy;

  assign busy     = ioRd | ioWr;
  // Ack beats a timeout landing in the same cycle.
  assign done     = busy & (ioAck | (toCnt == LAST));
  assign timedOut = busy & ~ioAck & (toCnt == LAST);

  // Strobe, address/data capture and timeout counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      ioRd    <= 1'b0;
      ioWr    <= 1'b0;
      ioAddr  <= '0;
      ioWdata <= '0;
      toCnt   <= '0;
      readAcc <= 1'b0;
    end else if (start) begin
      ioRd    <= isRead;
      ioWr    <= ~isRead;
      ioAddr  <= addr;
      ioWdata <= wdata;
      toCnt   <= '0;
      readAcc <= isRead;
    end else if (done) begin
      ioRd    <= 1'b0;
      ioWr    <= 1'b0;
    end else if (busy) begin
      toCnt   <= toCnt + 8'd1;
    end
  end
endmodule

// File: rtl/bus_sequencer.sv
// Sequences fetch, RAM data and IO accesses onto the shared bus; latches halt.
// Latency: RAM access pulses done/valid MEM_WAIT+2 cycles after the IDLE request.
// Backpressure: stall holds the core during data/IO access; fetch waits on if_valid.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int MEM_WAIT   = 1,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  input  logic              ex_valid,
  input  logic              ramLd,
  input  logic              ramSt,
  input  logic              ioR,
  input  logic              ioW,
  input  logic              halt,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              ex_done,
  output logic              stall,
  bus_sequencer_if.master   bus,
  output logic              io_err,
  output logic              op_err,
  output logic              halted
);
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

  seqState_t  state;
  logic [2:0] waitCnt;
  logic       haltPend;
  logic       accReq;
  logic       ramReq;
  logic       haltReq;
  logic       fetchReq;
  logic       ioStart;
  logic       ioDone;
  logic       ioTimedOut;
  logic       ioReadAcc;

  // In the done/valid cycle the core still presents the finished request; ignore it.
  assign accReq   = ex_valid & (ramLd | ramSt | ioR | ioW) & ~ex_done;
  assign ramReq   = ramLd | ramSt;
  assign haltReq  = ex_valid & halt & ~ex_done;
  assign fetchReq = if_req & ~if_valid;
  assign ioStart  = (state == IDLE) & accReq & ~ramReq;
  assign halted   = (state == HALTED);
  assign stall    = ((state == IDLE) & accReq) | (state == MEM_DATA) |
                    (state == IO_ACC) | (state == HALTED);

  io_handshake #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .IO_TIMEOUT(IO_TIMEOUT)
  ) uIo (
    .clk     (clk),
    .rst     (rst),
    .start   (ioStart),
    .isRead  (ioR),
    .addr    (ex_addr),
    .wdata   (ex_wdata),
    .ioAck   (bus.io_ack),
    .ioRd    (bus.io_rd),
    .ioWr    (bus.io_wr),
    .ioAddr  (bus.io_addr),
    .ioWdata (bus.io_wdata),
    .done    (ioDone),
    .timedOut(ioTimedOut),
    .readAcc (ioReadAcc)
  );

  // Arbitration, RAM wait-state sequencing and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      waitCnt       <= '0;
      haltPend      <= 1'b0;
      if_valid      <= 1'b0;
      if_data       <= '0;
      ex_done       <= 1'b0;
      ex_rdata      <= '0;
      io_err        <= 1'b0;
      op_err        <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      ex_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accReq) begin
            haltPend <= halt;
            if (multiBit(ramLd, ramSt, ioR, ioW)) op_err <= 1'b1;
            if (ramReq) begin
              state         <= MEM_DATA;
              bus.mem_addr  <= ex_addr;
              bus.mem_wdata <= ex_wdata;
              bus.mem_re    <= ramLd;
              bus.mem_we    <= ~ramLd;
              waitCnt       <= WAIT_LOAD;
            end else begin
              state <= IO_ACC;
            end
          end else if (haltReq) begin
            state <= HALTED;
          end else if (fetchReq) begin
            state        <= MEM_FETCH;
            bus.mem_addr <= if_addr;
            bus.mem_re   <= 1'b1;
            waitCnt      <= WAIT_LOAD;
          end
        end
        MEM_DATA, MEM_FETCH: begin
          if (waitCnt == 3'd0) begin
            bus.mem_re <= 1'b0;
            bus.mem_we <= 1'b0;
            if (state == MEM_FETCH) begin
              if_data  <= bus.mem_rdata;
              if_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              if (bus.mem_re) ex_rdata <= bus.mem_rdata;
              ex_done <= 1'b1;
              state   <= haltPend ? HALTED : IDLE;
            end
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end
        IO_ACC: begin
          if (ioDone) begin
            ex_done <= 1'b1;
            if (ioTimedOut) begin
              ex_rdata <= '0;
              io_err   <= 1'b1;
            end else if (ioReadAcc) begin
              ex_rdata <= bus.io_rdata;
            end
            state <= haltPend ? HALTED : IDLE;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
